// File: rtl/fifo_burst_packer_pkg.sv
// Shared types and constants for the FIFO burst packer: FSM state encoding
// and the width of the FIFO occupancy bus.
package fifo_burst_packer_pkg;

  localparam int C_COUNT_WIDTH = 18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_LAST = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_burst_packer_burst_len_normalize.sv
// Burst length normalisation: clamps the programmed length into 1..C_MAX_BURST
// and derives the length of a short burst from the current FIFO occupancy.
module burst_len_normalize
  import fifo_burst_packer_pkg::*;
#(
  parameter int C_MAX_BURST = 256,
  parameter int C_LEN_WIDTH = 9
) (
  input  logic [C_LEN_WIDTH-1:0]   burst_len,
  input  logic [C_COUNT_WIDTH-1:0] fifo_count,
  output logic [C_LEN_WIDTH-1:0]   eff_len,
  output logic [C_LEN_WIDTH-1:0]   short_len,
  output logic                     full_avail
);

  always_comb begin
    eff_len = burst_len;
    if (burst_len == '0) begin
      eff_len = C_LEN_WIDTH'(1);
    end else if (32'(burst_len) > C_MAX_BURST) begin
      eff_len = C_LEN_WIDTH'(C_MAX_BURST);
    end
    full_avail = (fifo_count >= C_COUNT_WIDTH'(eff_len));
    // When a full burst is not available the count is below eff_len, so it fits.
    short_len  = full_avail ? eff_len : fifo_count[C_LEN_WIDTH-1:0];
  end

endmodule

// File: rtl/fifo_burst_packer.sv
// Drains a first-word-fall-through FIFO in fixed-length bursts onto a
// valid/ready stream with a last marker; timeout or flush force short bursts.
module fifo_burst_packer
  import fifo_burst_packer_pkg::*;
#(
  parameter int C_DATA_WIDTH    = 128,
  parameter int C_MAX_BURST     = 256,
  parameter int C_LEN_WIDTH     = 9,
  parameter int C_TIMEOUT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  input  logic [C_DATA_WIDTH-1:0]    fifo_dataout,
  input  logic [C_COUNT_WIDTH-1:0]   fifo_count,
  output logic                       fifo_rden,
  input  logic [C_LEN_WIDTH-1:0]     burst_len,
  input  logic [C_TIMEOUT_WIDTH-1:0] timeout,
  input  logic                       flush,
  output logic                       m_valid,
  output logic [C_DATA_WIDTH-1:0]    m_data,
  output logic                       m_last,
  input  logic                       m_ready,
  output logic [C_LEN_WIDTH-1:0]     m_burst_len,
  output logic                       busy
);

  state_t                     state_q, state_d;
  logic [C_TIMEOUT_WIDTH-1:0] timer_q, timer_d;
  logic [C_LEN_WIDTH-1:0]     beats_rem_q, beats_rem_d;
  logic                       m_valid_q, m_valid_d;
  logic                       m_last_q, m_last_d;
  logic [C_DATA_WIDTH-1:0]    m_data_q, m_data_d;
  logic [C_LEN_WIDTH-1:0]     m_burst_len_q, m_burst_len_d;

  logic [C_LEN_WIDTH-1:0] eff_len;
  logic [C_LEN_WIDTH-1:0] short_len;
  logic                   full_avail;
  logic                   load;
  logic                   count_nz;
  logic                   timed_out;

  burst_len_normalize #(
    .C_MAX_BURST (C_MAX_BURST),
    .C_LEN_WIDTH (C_LEN_WIDTH)
  ) u_norm (
    .burst_len  (burst_len),
    .fifo_count (fifo_count),
    .eff_len    (eff_len),
    .short_len  (short_len),
    .full_avail (full_avail)
  );

  always_comb begin
    load = (state_q == ST_XFER) && (beats_rem_q != '0) && !fifo_empty
           && (!m_valid_q || m_ready);
    count_nz  = (fifo_count != '0);
    timed_out = (timeout != '0) && (timer_q == timeout - C_TIMEOUT_WIDTH'(1));

    state_d       = state_q;
    timer_d       = '0;
    beats_rem_d   = beats_rem_q;
    m_valid_d     = m_valid_q;
    m_last_d      = m_last_q;
    m_data_d      = m_data_q;
    m_burst_len_d = m_burst_len_q;

    case (state_q)
      ST_IDLE: begin
        if (full_avail) begin
          m_burst_len_d = eff_len;
          beats_rem_d   = eff_len;
          state_d       = ST_XFER;
        end else if (count_nz && (flush || timed_out)) begin
          m_burst_len_d = short_len;
          beats_rem_d   = short_len;
          state_d       = ST_XFER;
        end else if (count_nz) begin
          // Partial data waiting: age it, saturating rather than wrapping.
          timer_d = (timer_q == '1) ? timer_q : timer_q + C_TIMEOUT_WIDTH'(1);
        end
      end
      ST_XFER: begin
        if (load) begin
          m_data_d    = fifo_dataout;
          m_valid_d   = 1'b1;
          beats_rem_d = beats_rem_q - C_LEN_WIDTH'(1);
          if (beats_rem_q == C_LEN_WIDTH'(1)) begin
            m_last_d = 1'b1;
            state_d  = ST_LAST;
          end
        end else if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
        end
      end
      ST_LAST: begin
        if (m_valid_q && m_ready && m_last_q) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      beats_rem_q   <= '0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      m_data_q      <= '0;
      m_burst_len_q <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      beats_rem_q   <= beats_rem_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      m_data_q      <= m_data_d;
      m_burst_len_q <= m_burst_len_d;
    end
  end

  assign fifo_rden   = load;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign m_data      = m_data_q;
  assign m_burst_len = m_burst_len_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_burst_packer.sv
// Self-checking bench: a queue-based FWFT FIFO feeds the packer, and a
// burst-level model predicts beat data, burst lengths and last markers.
module tb_fifo_burst_packer;
  import fifo_burst_packer_pkg::*;

  localparam int DW   = 128;
  localparam int MAXB = 256;
  localparam int LW   = 9;
  localparam int TW   = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     fifo_empty;
  logic [DW-1:0]            fifo_dataout;
  logic [C_COUNT_WIDTH-1:0] fifo_count;
  logic                     fifo_rden;
  logic [LW-1:0]            burst_len;
  logic [TW-1:0]            timeout;
  logic                     flush;
  logic                     m_valid;
  logic [DW-1:0]            m_data;
  logic                     m_last;
  logic                     m_ready;
  logic [LW-1:0]            m_burst_len;
  logic                     busy;

  fifo_burst_packer #(
    .C_DATA_WIDTH    (DW),
    .C_MAX_BURST     (MAXB),
    .C_LEN_WIDTH     (LW),
    .C_TIMEOUT_WIDTH (TW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_dataout (fifo_dataout),
    .fifo_count   (fifo_count),
    .fifo_rden    (fifo_rden),
    .burst_len    (burst_len),
    .timeout      (timeout),
    .flush        (flush),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .m_burst_len  (m_burst_len),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- FWFT FIFO model ----------------
  logic [DW-1:0] fq[$];
  logic [DW-1:0] pend[$];
  bit            fifo_clr = 1'b0;
  bit            pop_now;
  int            n_pops = 0;

  always @(posedge clk) begin
    pop_now = fifo_rden;
    #1;
    if (fifo_clr) begin
      fq.delete();
      fifo_clr = 1'b0;
    end else if (pop_now && fq.size() > 0) begin
      void'(fq.pop_front());
      n_pops++;
    end
    while (pend.size() > 0) fq.push_back(pend.pop_front());
    fifo_count   = C_COUNT_WIDTH'(fq.size());
    fifo_empty   = (fq.size() == 0);
    fifo_dataout = (fq.size() > 0) ? fq[0] : '0;
  end

  // ---------------- sink ready generator ----------------
  int ready_mode = 0;
  int rp = 0;
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       begin m_ready = (rp % 3 == 0); rp++; end
      default: m_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- burst-level reference model ----------------
  logic [DW-1:0] exp_data[$];
  int            exp_len[$];
  int            beat_idx = 0;
  int            n_acc = 0;
  int            cyc = 0;
  int            acc_cyc[$];
  int            first_len = 0;
  bit            mon_en = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  function automatic int eff(input int l);
    if (l == 0) return 1;
    if (l > MAXB) return MAXB;
    return l;
  endfunction

  // Words are delivered in FIFO order; full bursts first, then an optional residue.
  function automatic int predict(input int n, input int l, input bit drain_rest);
    int e;
    e = eff(l);
    while (n >= e) begin
      exp_len.push_back(e);
      n -= e;
    end
    if (n > 0 && drain_rest) begin
      exp_len.push_back(n);
      n = 0;
    end
    return n;
  endfunction

  task automatic push_words(input int n);
    logic [DW-1:0] w;
    @(posedge clk);
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      pend.push_back(w);
      exp_data.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] ed;
    int            l;
    cyc++;
    if (!mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (fifo_rden) check("rden_while_empty", fifo_empty, 1'b0);
      if (prev_stall) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", m_data, prev_data);
        check("hold_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        if (exp_data.size() == 0 || exp_len.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          ed = exp_data.pop_front();
          l  = exp_len[0];
          check("beat_data", m_data, ed);
          check("beat_last", m_last, (beat_idx == l - 1));
          check("beat_burst_len", m_burst_len, l);
          if (beat_idx == 0) first_len = int'(m_burst_len);
          n_acc++;
          acc_cyc.push_back(cyc);
          if (beat_idx == l - 1) begin
            void'(exp_len.pop_front());
            beat_idx = 0;
          end else begin
            beat_idx++;
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // Wait for all predicted bursts, then confirm the block is idle with the expected leftover.
  task automatic drain(input string name, input int leftover);
    int t;
    t = 0;
    while (exp_len.size() > 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_timeout"}, (t < 5000), 1'b1);
    repeat (3) @(negedge clk);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_valid"}, m_valid, 1'b0);
    check({name, "_fifo_left"}, fifo_count, leftover);
    check({name, "_model_left"}, exp_data.size(), leftover);
  endtask

  initial begin
    int idle_cnt, rem, acc0, t, n, l;
    rst = 1'b1; flush = 1'b0; timeout = '0; burst_len = LW'(4); m_ready = 1'b1;
    fifo_count = '0; fifo_empty = 1'b1; fifo_dataout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", m_valid, 1'b0);
    check("rst_last", m_last, 1'b0);
    check("rst_data", m_data, '0);
    check("rst_burst_len", m_burst_len, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_rden", fifo_rden, 1'b0);
    @(posedge clk); #3; rst = 1'b0; mon_en = 1'b1;

    // Two back-to-back full bursts of 4 with a bubble between them.
    acc_cyc.delete();
    burst_len = LW'(4);
    push_words(8);
    rem = predict(8, 4, 1'b0);
    drain("two_bursts", 0);
    check("two_bursts_beats", acc_cyc.size(), 8);
    if (acc_cyc.size() == 8) begin
      check("throughput_gap", acc_cyc[1] - acc_cyc[0], 1);
      check("bubble_gap", acc_cyc[4] - acc_cyc[3], 3);
    end

    // Timeout forces a 3-beat short burst after 10 idle cycles.
    @(negedge clk);
    burst_len = LW'(8); timeout = TW'(10);
    push_words(3);
    rem = predict(3, 8, 1'b1);
    idle_cnt = 0;
    t = 0;
    while (t < 100) begin
      @(negedge clk);
      t++;
      if (busy) break;
      if (fifo_count != '0) idle_cnt++;
    end
    check("timeout_idle_cycles", idle_cnt, 10);
    drain("timeout_burst", 0);
    check("timeout_first_len", first_len, 3);
    timeout = '0;

    // Flush pulse with two words buffered.
    burst_len = LW'(4);
    push_words(2);
    repeat (3) begin
      @(negedge clk);
      check("no_start_without_flush", busy, 1'b0);
    end
    flush = 1'b1;
    rem = predict(2, 4, 1'b1);
    @(negedge clk);
    check("flush_starts_next_cycle", busy, 1'b1);
    flush = 1'b0;
    drain("flush_burst", 0);
    flush = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("flush_empty_idle", busy, 1'b0);
    end
    flush = 1'b0;

    // Sink back-pressure 1,0,0 repeating.
    ready_mode = 1; rp = 0; n_pops = 0;
    push_words(4);
    rem = predict(4, 4, 1'b0);
    drain("backpressure", 0);
    check("backpressure_pops", n_pops, 4);
    ready_mode = 0;

    // Zero length means single-beat bursts.
    @(negedge clk);
    burst_len = '0;
    push_words(3);
    rem = predict(3, 0, 1'b0);
    drain("len_zero", 0);

    // Oversized length clamps; a mid-burst length change is ignored.
    @(negedge clk);
    burst_len = LW'(300);
    push_words(300);
    rem = predict(300, 300, 1'b0);
    repeat (20) @(negedge clk);
    burst_len = LW'(7);
    repeat (5) @(negedge clk);
    burst_len = LW'(300);
    drain("clamp_256", 44);
    check("clamp_first_len", first_len, 256);
    flush = 1'b1;
    exp_len.push_back(rem);
    drain("clamp_residue", 0);
    flush = 1'b0;

    // Reset during beat 2 of a 4-beat burst, then a clean burst.
    burst_len = LW'(4);
    push_words(4);
    rem = predict(4, 4, 1'b0);
    acc0 = n_acc;
    t = 0;
    while (n_acc < acc0 + 1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("reset_wait_first_beat", (t < 200), 1'b1);
    @(posedge clk); #3;
    mon_en = 1'b0; rst = 1'b1; fifo_clr = 1'b1;
    exp_data.delete(); exp_len.delete(); beat_idx = 0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_valid", m_valid, 1'b0);
    check("midreset_busy", busy, 1'b0);
    @(posedge clk); #3;
    rst = 1'b0; mon_en = 1'b1;
    push_words(4);
    rem = predict(4, 4, 1'b0);
    drain("after_reset", 0);
    check("after_reset_len", first_len, 4);

    // Randomised phases: random length, size, drain mode and back-pressure.
    ready_mode = 2;
    for (int it = 0; it < 25; it++) begin
      @(negedge clk);
      l = $urandom_range(0, 9);
      n = $urandom_range(0, 20);
      burst_len = LW'(l);
      if ($urandom_range(0, 1) == 1) flush = 1'b1;
      else timeout = TW'($urandom_range(1, 6));
      push_words(n);
      rem = predict(n, l, 1'b1);
      drain("random_phase", 0);
      flush = 1'b0;
      timeout = '0;
    end
    ready_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
